// File: rtl/coin_pkg.sv
// Shared definitions for the coin accumulator: coin codes, their values,
// FSM state encoding and the invalid-coin sentinel.
package coin_pkg;

    // Coin codes on moeda; any code with bit 2 set is invalid
    localparam logic [2:0] MOEDA_R1  = 3'b000;
    localparam logic [2:0] MOEDA_R2  = 3'b001;
    localparam logic [2:0] MOEDA_R5  = 3'b010;
    localparam logic [2:0] MOEDA_R10 = 3'b011;

    // Value of each coin in reais
    localparam logic [4:0] VALOR_R1  = 5'd1;
    localparam logic [4:0] VALOR_R2  = 5'd2;
    localparam logic [4:0] VALOR_R5  = 5'd5;
    localparam logic [4:0] VALOR_R10 = 5'd10;

    // Presented on soma when the transaction saw a bad coin or an overflow
    localparam logic [4:0] SOMA_INVALIDA = 5'b11111;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAcum   = 2'b01,
        StPronto = 2'b10,
        StInval  = 2'b11
    } state_t;

    // Value table lookup; invalid codes map to zero
    function automatic logic [4:0] coin_value(input logic [2:0] code);
        logic [4:0] valor;
        valor = 5'd0;
        if (!code[2]) begin
            case (code)
                MOEDA_R1:  valor = VALOR_R1;
                MOEDA_R2:  valor = VALOR_R2;
                MOEDA_R5:  valor = VALOR_R5;
                MOEDA_R10: valor = VALOR_R10;
                default:   valor = 5'd0;
            endcase
        end
        return valor;
    endfunction

endpackage

// File: rtl/coin_accumulator_if.sv
// Handshake bundle between the transaction controller / coin slot (master)
// and the coin accumulator (slave).
interface coin_accumulator_if;

    logic       moeda_strobe;
    logic [2:0] moeda;
    logic       confirma;
    logic       cancela;
    logic       limpa;
    logic [4:0] soma;
    logic       soma_valida;
    logic       devolve;
    logic [4:0] devolve_valor;

    modport master (
        output moeda_strobe, moeda, confirma, cancela, limpa,
        input  soma, soma_valida, devolve, devolve_valor
    );

    modport slave (
        input  moeda_strobe, moeda, confirma, cancela, limpa,
        output soma, soma_valida, devolve, devolve_valor
    );

endinterface

// File: rtl/coin_decoder.sv
// Combinational coin-code decoder: moeda -> {valida, valor}.
module coin_decoder
    import coin_pkg::*;
(
    input  logic [2:0] moeda,
    output logic       valida,
    output logic [4:0] valor
);

    // Bit 2 marks an invalid code; otherwise look up the value table
    always_comb begin
        valida = ~moeda[2];
        valor  = coin_value(moeda);
    end

endmodule

// File: rtl/coin_accumulator.sv
// Coin accumulator: decodes coin strobes, accumulates credit, freezes it for the
// coin-error checker and returns credit on cancel, bad coin or overflow.
// Optional idle timeout in ACUM is enabled by defining COIN_TIMEOUT_EN.
module coin_accumulator
    import coin_pkg::*;
#(
    parameter int unsigned MAX_SOMA = 30
`ifdef COIN_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned CNT_W       = 10
`endif
) (
    input logic              clock,
    input logic              reset,
    coin_accumulator_if.slave bus
);

    localparam logic [5:0] MAX_SOMA6 = 6'(MAX_SOMA);

    state_t     state_q, state_d;
    logic [4:0] soma_q, soma_d;
    logic       devolve_q, devolve_d;
    logic [4:0] devolve_valor_q, devolve_valor_d;

    logic       coin_valida;
    logic [4:0] coin_valor;
    logic [5:0] sum6;
    logic       in_idle, in_acum, in_held;
    logic       timeout;
    logic       coin_live;
    logic       ev_cancel, ev_confirm, ev_coin_ok, ev_coin_bad, ev_limpa;

    coin_decoder u_decoder (
        .moeda  (bus.moeda),
        .valida (coin_valida),
        .valor  (coin_valor)
    );

    // soma_q is always 0 in IDLE, so one adder serves both the first and later coins
    assign sum6 = {1'b0, soma_q} + {1'b0, coin_valor};

    // Decode the single event taken this cycle; cancel/timeout beat confirm beat coin
    always_comb begin
        in_idle     = (state_q == StIdle);
        in_acum     = (state_q == StAcum);
        in_held     = (state_q == StPronto) || (state_q == StInval);
        ev_cancel   = in_acum && (bus.cancela || timeout);
        ev_confirm  = in_acum && !ev_cancel && bus.confirma;
        coin_live   = bus.moeda_strobe &&
                      (in_idle || (in_acum && !ev_cancel && !bus.confirma));
        ev_coin_ok  = coin_live && coin_valida && (sum6 <= MAX_SOMA6);
        ev_coin_bad = coin_live && !ev_coin_ok;
        ev_limpa    = in_held && bus.limpa;
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StAcum: begin
                if (ev_cancel) begin
                    state_d = StIdle;
                end else if (ev_confirm) begin
                    state_d = StPronto;
                end else if (ev_coin_ok) begin
                    state_d = StAcum;
                end else if (ev_coin_bad) begin
                    state_d = StInval;
                end
            end
            StPronto, StInval: begin
                if (ev_limpa) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: soma is frozen for the checker in PRONTO and INVAL
    always_comb begin
        bus.soma_valida = (state_q == StPronto) || (state_q == StInval);
    end

    // Datapath next values: credit update and return pulse
    always_comb begin
        soma_d = soma_q;
        if (ev_cancel || ev_limpa) begin
            soma_d = 5'd0;
        end else if (ev_coin_ok) begin
            soma_d = sum6[4:0];
        end else if (ev_coin_bad) begin
            soma_d = SOMA_INVALIDA;
        end
        // A bad coin returns what was already inserted; nothing to return from IDLE
        devolve_d       = ev_cancel || (ev_coin_bad && (soma_q != 5'd0));
        devolve_valor_d = devolve_d ? soma_q : 5'd0;
    end

    // Datapath registers; reset discards credit without a return pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            soma_q          <= 5'd0;
            devolve_q       <= 1'b0;
            devolve_valor_q <= 5'd0;
        end else begin
            soma_q          <= soma_d;
            devolve_q       <= devolve_d;
            devolve_valor_q <= devolve_valor_d;
        end
    end

    assign bus.soma          = soma_q;
    assign bus.devolve       = devolve_q;
    assign bus.devolve_valor = devolve_valor_q;

`ifdef COIN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = in_acum && (cnt_q == CNT_LAST);

    // Idle counter: restarts on every accepted coin, parked at 0 outside ACUM
    always_comb begin
        if ((state_d != StAcum) || ev_coin_ok) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Idle counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed self-checking bench for coin_accumulator.
// With COIN_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYC=8.
module tb_coin_accumulator;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;

    coin_accumulator_if bus ();

`ifdef COIN_TIMEOUT_EN
    coin_accumulator #(.MAX_SOMA(30), .TIMEOUT_CYC(8), .CNT_W(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );
`else
    coin_accumulator #(.MAX_SOMA(30)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic coin(input logic [2:0] code);
        bus.moeda        = code;
        bus.moeda_strobe = 1'b1;
        tick();
        bus.moeda_strobe = 1'b0;
        bus.moeda        = 3'b000;
    endtask

    task automatic pulse_limpa();
        bus.limpa = 1'b1;
        tick();
        bus.limpa = 1'b0;
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        bus.moeda_strobe = 1'b0;
        bus.moeda        = 3'b000;
        bus.confirma     = 1'b0;
        bus.cancela      = 1'b0;
        bus.limpa        = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.soma !== 5'd0) $display("FAIL rst_soma: got %0d want 0", bus.soma); else n_pass++;
        n_checks++; if (bus.soma_valida !== 1'b0) $display("FAIL rst_valida: got %b want 0", bus.soma_valida); else n_pass++;
        n_checks++; if (bus.devolve !== 1'b0) $display("FAIL rst_devolve: got %b want 0", bus.devolve); else n_pass++;
        n_checks++; if (bus.devolve_valor !== 5'd0) $display("FAIL rst_dvalor: got %0d want 0", bus.devolve_valor); else n_pass++;
        reset = 1'b0;
        // confirma/cancela ignored in IDLE
        bus.confirma = 1'b1;
        bus.cancela  = 1'b1;
        tick();
        bus.confirma = 1'b0;
        bus.cancela  = 1'b0;
        n_checks++; if (bus.soma_valida !== 1'b0 || bus.devolve !== 1'b0)
            $display("FAIL idle_ignore: got valida=%b devolve=%b want 0 0", bus.soma_valida, bus.devolve); else n_pass++;
    endtask

    task automatic test_accumulate();
        coin(3'b001);
        n_checks++; if (bus.soma !== 5'd2) $display("FAIL acc_first: got %0d want 2", bus.soma); else n_pass++;
        coin(3'b000);
        coin(3'b001);
        n_checks++; if (bus.soma !== 5'd5 || bus.soma_valida !== 1'b0)
            $display("FAIL acc_sum: got soma=%0d valida=%b want 5 0", bus.soma, bus.soma_valida); else n_pass++;
        // limpa ignored in ACUM
        pulse_limpa();
        n_checks++; if (bus.soma !== 5'd5) $display("FAIL acc_limpa_ign: got %0d want 5", bus.soma); else n_pass++;
        bus.confirma = 1'b1;
        tick();
        bus.confirma = 1'b0;
        n_checks++; if (bus.soma !== 5'd5 || bus.soma_valida !== 1'b1)
            $display("FAIL pronto: got soma=%0d valida=%b want 5 1", bus.soma, bus.soma_valida); else n_pass++;
        // coins and cancela ignored while frozen
        coin(3'b011);
        bus.cancela = 1'b1;
        tick();
        bus.cancela = 1'b0;
        n_checks++; if (bus.soma !== 5'd5 || bus.soma_valida !== 1'b1 || bus.devolve !== 1'b0)
            $display("FAIL pronto_hold: got soma=%0d valida=%b devolve=%b want 5 1 0",
                     bus.soma, bus.soma_valida, bus.devolve); else n_pass++;
        pulse_limpa();
        n_checks++; if (bus.soma !== 5'd0 || bus.soma_valida !== 1'b0)
            $display("FAIL pronto_limpa: got soma=%0d valida=%b want 0 0", bus.soma, bus.soma_valida); else n_pass++;
    endtask

    task automatic test_invalid();
        coin(3'b001);
        coin(3'b001);
        coin(3'b100);
        n_checks++; if (bus.soma !== 5'd31 || bus.soma_valida !== 1'b1)
            $display("FAIL inv_soma: got soma=%0d valida=%b want 31 1", bus.soma, bus.soma_valida); else n_pass++;
        n_checks++; if (bus.devolve !== 1'b1 || bus.devolve_valor !== 5'd4)
            $display("FAIL inv_devolve: got devolve=%b valor=%0d want 1 4", bus.devolve, bus.devolve_valor); else n_pass++;
        tick();
        n_checks++; if (bus.devolve !== 1'b0 || bus.soma !== 5'd31)
            $display("FAIL inv_hold: got devolve=%b soma=%0d want 0 31", bus.devolve, bus.soma); else n_pass++;
        pulse_limpa();
        // invalid coin straight from IDLE: nothing to return
        coin(3'b111);
        n_checks++; if (bus.soma !== 5'd31 || bus.soma_valida !== 1'b1 || bus.devolve !== 1'b0)
            $display("FAIL inv_idle: got soma=%0d valida=%b devolve=%b want 31 1 0",
                     bus.soma, bus.soma_valida, bus.devolve); else n_pass++;
        pulse_limpa();
        n_checks++; if (bus.soma !== 5'd0) $display("FAIL inv_limpa: got %0d want 0", bus.soma); else n_pass++;
    endtask

    task automatic test_overflow();
        coin(3'b011);
        coin(3'b011);
        coin(3'b011);
        n_checks++; if (bus.soma !== 5'd30 || bus.soma_valida !== 1'b0)
            $display("FAIL ovf_limit: got soma=%0d valida=%b want 30 0", bus.soma, bus.soma_valida); else n_pass++;
        coin(3'b000);
        n_checks++; if (bus.soma !== 5'd31 || bus.devolve !== 1'b1 || bus.devolve_valor !== 5'd30)
            $display("FAIL ovf_inval: got soma=%0d devolve=%b valor=%0d want 31 1 30",
                     bus.soma, bus.devolve, bus.devolve_valor); else n_pass++;
        pulse_limpa();
    endtask

    task automatic test_priority();
        coin(3'b010);
        coin(3'b001);
        bus.cancela      = 1'b1;
        bus.confirma     = 1'b1;
        bus.moeda_strobe = 1'b1;
        bus.moeda        = 3'b000;
        tick();
        bus.cancela      = 1'b0;
        bus.confirma     = 1'b0;
        bus.moeda_strobe = 1'b0;
        n_checks++; if (bus.devolve !== 1'b1 || bus.devolve_valor !== 5'd7)
            $display("FAIL prio_devolve: got devolve=%b valor=%0d want 1 7", bus.devolve, bus.devolve_valor); else n_pass++;
        n_checks++; if (bus.soma !== 5'd0 || bus.soma_valida !== 1'b0)
            $display("FAIL prio_idle: got soma=%0d valida=%b want 0 0", bus.soma, bus.soma_valida); else n_pass++;
        tick();
        n_checks++; if (bus.devolve !== 1'b0 || bus.devolve_valor !== 5'd0)
            $display("FAIL prio_pulse: got devolve=%b valor=%0d want 0 0", bus.devolve, bus.devolve_valor); else n_pass++;
        // confirma beats a same-cycle coin
        coin(3'b000);
        bus.confirma     = 1'b1;
        bus.moeda_strobe = 1'b1;
        bus.moeda        = 3'b011;
        tick();
        bus.confirma     = 1'b0;
        bus.moeda_strobe = 1'b0;
        bus.moeda        = 3'b000;
        n_checks++; if (bus.soma !== 5'd1 || bus.soma_valida !== 1'b1)
            $display("FAIL prio_confirm: got soma=%0d valida=%b want 1 1", bus.soma, bus.soma_valida); else n_pass++;
        pulse_limpa();
    endtask

    task automatic test_async_reset();
        coin(3'b011);
        bus.confirma = 1'b1;
        tick();
        bus.confirma = 1'b0;
        n_checks++; if (bus.soma !== 5'd10 || bus.soma_valida !== 1'b1)
            $display("FAIL ares_pronto: got soma=%0d valida=%b want 10 1", bus.soma, bus.soma_valida); else n_pass++;
        #3;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.soma !== 5'd0 || bus.soma_valida !== 1'b0)
            $display("FAIL ares_now: got soma=%0d valida=%b want 0 0", bus.soma, bus.soma_valida); else n_pass++;
        tick();
        n_checks++; if (bus.devolve !== 1'b0) $display("FAIL ares_nodev: got %b want 0", bus.devolve); else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++; if (bus.devolve !== 1'b0 || bus.soma !== 5'd0)
            $display("FAIL ares_after: got devolve=%b soma=%0d want 0 0", bus.devolve, bus.soma); else n_pass++;
    endtask

    task automatic test_timeout();
        int seen;
`ifdef COIN_TIMEOUT_EN
        coin(3'b010);
        seen = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus.devolve === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL to_early: got %0d pulses want 0", seen); else n_pass++;
        tick();
        n_checks++; if (bus.devolve !== 1'b1 || bus.devolve_valor !== 5'd5 || bus.soma !== 5'd0)
            $display("FAIL to_fire: got devolve=%b valor=%0d soma=%0d want 1 5 0",
                     bus.devolve, bus.devolve_valor, bus.soma); else n_pass++;
        tick();
        // restart: second coin on the 6th edge after the first
        coin(3'b010);
        for (int i = 0; i < 5; i++) tick();
        coin(3'b000);
        seen = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus.devolve === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL to_restart: got %0d pulses want 0", seen); else n_pass++;
        tick();
        n_checks++; if (bus.devolve !== 1'b1 || bus.devolve_valor !== 5'd6)
            $display("FAIL to_refire: got devolve=%b valor=%0d want 1 6", bus.devolve, bus.devolve_valor); else n_pass++;
        tick();
`else
        coin(3'b010);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.devolve === 1'b1) seen++;
        end
        n_checks++; if (seen != 0 || bus.soma !== 5'd5)
            $display("FAIL no_timeout: got pulses=%0d soma=%0d want 0 5", seen, bus.soma); else n_pass++;
        bus.cancela = 1'b1;
        tick();
        bus.cancela = 1'b0;
        n_checks++; if (bus.devolve !== 1'b1 || bus.devolve_valor !== 5'd5)
            $display("FAIL late_cancel: got devolve=%b valor=%0d want 1 5", bus.devolve, bus.devolve_valor); else n_pass++;
        tick();
`endif
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_accumulate();
        test_invalid();
        test_overflow();
        test_priority();
        test_async_reset();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
